// File: rtl/aes_ctrl_shadow_pkg.sv
// Shared types and default field layout for the AES control shadow register bank.
package aes_ctrl_shadow_pkg;

    // Two-phase commit protocol state: IDLE waits for a first write,
    // STAGED holds it until the confirming write arrives.
    typedef enum logic {
        IDLE   = 1'b0,
        STAGED = 1'b1
    } phase_e;

    // Default AES control field indices (field f lives at bits [f*FieldW +: FieldW]).
    localparam int unsigned AES_OP_IDX       = 0;
    localparam int unsigned AES_MODE_IDX     = 1;
    localparam int unsigned AES_KEYLEN_IDX   = 2;
    localparam int unsigned AES_SIDELOAD_IDX = 3;
    localparam int unsigned AES_PRNG_IDX     = 4;
    localparam int unsigned AES_MANUAL_IDX   = 5;

    localparam int unsigned NUM_FIELDS_DEFAULT = 6;
    localparam int unsigned FIELD_W_DEFAULT    = 6;
    localparam int unsigned DW_DEFAULT         = NUM_FIELDS_DEFAULT * FIELD_W_DEFAULT;

    // Concatenations list field 5 first, so field 0 ends up at the LSB.
    localparam logic [DW_DEFAULT-1:0] FIELD_MASK_DEFAULT =
        {6'h01, 6'h07, 6'h01, 6'h07, 6'h3F, 6'h03};
    localparam logic [NUM_FIELDS_DEFAULT-1:0] FIELD_ONEHOT_DEFAULT = 6'b010_110;
    localparam logic [DW_DEFAULT-1:0] ALLOWED_MASK_DEFAULT =
        {6'h00, 6'h07, 6'h00, 6'h07, 6'h3F, 6'h03};
    localparam logic [DW_DEFAULT-1:0] DEFAULT_VAL_DEFAULT =
        {6'h00, 6'h01, 6'h00, 6'h04, 6'h20, 6'h01};
    localparam logic [DW_DEFAULT-1:0] RES_VAL_DEFAULT =
        {6'h00, 6'h01, 6'h00, 6'h01, 6'h20, 6'h01};

endpackage : aes_ctrl_shadow_pkg

// File: rtl/aes_ctrl_field_legalize.sv
// Combinational legalisation of one control field: mask off unused bits and,
// for one-hot fields, replace any non-one-hot or disallowed code by a default.
module aes_ctrl_field_legalize #(
    parameter int unsigned       FieldW  = 6,
    parameter logic [FieldW-1:0] Mask    = '1,
    parameter bit                OneHot  = 1'b0,
    parameter logic [FieldW-1:0] Allowed = '1,
    parameter logic [FieldW-1:0] Default = '0
) (
    input  logic [FieldW-1:0] d_i,
    output logic [FieldW-1:0] q_o
);

    logic [FieldW-1:0] masked;

    assign masked = d_i & Mask;

    if (OneHot) begin : g_onehot
        logic is_onehot;
        logic in_allowed;

        // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
        assign is_onehot  = (masked != '0) && ((masked & (masked - FieldW'(1))) == '0);
        assign in_allowed = (masked & ~Allowed) == '0;
        assign q_o        = (is_onehot && in_allowed) ? masked : Default;
    end else begin : g_plain
        assign q_o = masked;
    end

endmodule : aes_ctrl_field_legalize

// File: rtl/aes_ctrl_shadow_bank.sv
// Shadowed control-register bank for the AES control path. All fields are
// legalised, staged on a first write and committed together on an identical
// second write; a redundant inverted shadow copy guards the committed value.
module aes_ctrl_shadow_bank
    import aes_ctrl_shadow_pkg::*;
#(
    parameter int unsigned                          NumFields   = NUM_FIELDS_DEFAULT,
    parameter int unsigned                          FieldW      = FIELD_W_DEFAULT,
    parameter logic [NumFields*FieldW-1:0]          FieldMask   = FIELD_MASK_DEFAULT,
    parameter logic [NumFields-1:0]                 FieldOneHot = FIELD_ONEHOT_DEFAULT,
    parameter logic [NumFields*FieldW-1:0]          AllowedMask = ALLOWED_MASK_DEFAULT,
    parameter logic [NumFields*FieldW-1:0]          DefaultVal  = DEFAULT_VAL_DEFAULT,
    parameter logic [NumFields*FieldW-1:0]          ResVal      = RES_VAL_DEFAULT,
    localparam int unsigned                         DW          = NumFields * FieldW
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          we_i,
    input  logic          re_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          busy_i,
    output logic [DW-1:0] q_o,
    output logic          qe_o,
    output logic          phase_o,
    output logic          err_update_o,
    output logic          err_storage_o,
    output logic          write_ignored_o
);

    phase_e        state_q, state_d;
    logic [DW-1:0] lw;
    logic [DW-1:0] staged_q, staged_d;
    logic [DW-1:0] q_q, q_d;
    logic [DW-1:0] shadow_q, shadow_d;
    logic          qe_q, qe_d;
    logic          err_update_q, err_update_d;
    logic          err_storage_q, err_storage_d;
    logic          write_ignored_q, write_ignored_d;
    logic          wr_ok;
    logic          wr_drop;

    // A write is accepted only while the core is idle; otherwise it is dropped.
    assign wr_ok   = we_i & ~busy_i;
    assign wr_drop = we_i & busy_i;

    // Per-field legalisation of the raw write data.
    for (genvar f = 0; f < NumFields; f++) begin : g_field
        aes_ctrl_field_legalize #(
            .FieldW  (FieldW),
            .Mask    (FieldMask[f*FieldW +: FieldW]),
            .OneHot  (FieldOneHot[f]),
            .Allowed (AllowedMask[f*FieldW +: FieldW]),
            .Default (DefaultVal[f*FieldW +: FieldW])
        ) u_legalize (
            .d_i (wdata_i[f*FieldW +: FieldW]),
            .q_o (lw[f*FieldW +: FieldW])
        );
    end

    // FSM state register.
    // NOTE: sequential state uses non-blocking (<=) assignments so every flop
    // samples its inputs from before the clock edge, independent of block order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: a valid write advances the protocol; a read alone abandons staging.
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (wr_ok) begin
                    state_d = STAGED;
                end
            end
            STAGED: begin
                if (wr_ok || (re_i && !we_i)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: staging, commit/mismatch decision and next values of the pulse flags.
    always_comb begin
        staged_d        = staged_q;
        q_d             = q_q;
        shadow_d        = shadow_q;
        qe_d            = 1'b0;
        err_update_d    = 1'b0;
        write_ignored_d = wr_drop;
        err_storage_d   = err_storage_q | (q_q != ~shadow_q);
        case (state_q)
            IDLE: begin
                if (wr_ok) begin
                    staged_d = lw;
                end
            end
            STAGED: begin
                if (wr_ok) begin
                    if (lw == staged_q) begin
                        q_d      = lw;
                        shadow_d = ~lw;
                        qe_d     = 1'b1;
                    end else begin
                        err_update_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // Data and flag registers.
    // NOTE: all storage here, including the staging register, has an
    // architecturally defined reset value, so every flop sits on rst_ni.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            staged_q        <= '0;
            q_q             <= ResVal;
            shadow_q        <= ~ResVal;
            qe_q            <= 1'b0;
            err_update_q    <= 1'b0;
            err_storage_q   <= 1'b0;
            write_ignored_q <= 1'b0;
        end else begin
            staged_q        <= staged_d;
            q_q             <= q_d;
            shadow_q        <= shadow_d;
            qe_q            <= qe_d;
            err_update_q    <= err_update_d;
            err_storage_q   <= err_storage_d;
            write_ignored_q <= write_ignored_d;
        end
    end

    assign q_o             = q_q;
    assign qe_o            = qe_q;
    assign phase_o         = (state_q == STAGED);
    assign err_update_o    = err_update_q;
    assign err_storage_o   = err_storage_q;
    assign write_ignored_o = write_ignored_q;

endmodule : aes_ctrl_shadow_bank

// File: tb/tb_aes_ctrl_shadow_bank.sv
// Scoreboard bench for aes_ctrl_shadow_bank: directed vectors push hand-computed
// expected outputs; a monitor pops and compares them after every clock edge.
module tb_aes_ctrl_shadow_bank;

    localparam int DW = 36;

    typedef struct {
        string          name;
        logic [DW-1:0]  q;
        logic [4:0]     flags;  // {qe, phase, err_update, err_storage, write_ignored}
    } exp_t;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          we_i = 1'b0;
    logic          re_i = 1'b0;
    logic          busy_i = 1'b0;
    logic [DW-1:0] wdata_i = '0;
    logic [DW-1:0] q_o;
    logic          qe_o;
    logic          phase_o;
    logic          err_update_o;
    logic          err_storage_o;
    logic          write_ignored_o;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    aes_ctrl_shadow_bank dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .we_i            (we_i),
        .re_i            (re_i),
        .wdata_i         (wdata_i),
        .busy_i          (busy_i),
        .q_o             (q_o),
        .qe_o            (qe_o),
        .phase_o         (phase_o),
        .err_update_o    (err_update_o),
        .err_storage_o   (err_storage_o),
        .write_ignored_o (write_ignored_o)
    );

    always #5 clk_i = ~clk_i;

    // Field 0 is the LSB; arguments run from field 5 down to field 0.
    function automatic logic [DW-1:0] mk(input logic [5:0] f5, f4, f3, f2, f1, f0);
        return {f5, f4, f3, f2, f1, f0};
    endfunction

    // Legal write with the given mode and key length; other fields at reset-compatible codes.
    function automatic logic [DW-1:0] w(input logic [5:0] mode, input logic [5:0] keylen);
        return mk(6'h00, 6'h01, 6'h00, keylen, mode, 6'h01);
    endfunction

    task automatic check(input string name, input string what,
                         input logic [DW-1:0] act, input logic [DW-1:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s.%s: got %h expected %h", name, what, act, exp);
        end
    endtask

    // Drive one cycle of stimulus and record what the outputs must be after the edge.
    task automatic apply(input string name, input logic rst, input logic we,
                         input logic re, input logic busy, input logic [DW-1:0] wd,
                         input logic flip, input logic [DW-1:0] eq, input logic [4:0] ef);
        exp_t e;
        @(negedge clk_i);
        if (flip) dut.shadow_q[6] = ~dut.shadow_q[6];
        rst_ni  = rst;
        we_i    = we;
        re_i    = re;
        busy_i  = busy;
        wdata_i = wd;
        e.name  = name;
        e.q     = eq;
        e.flags = ef;
        exp_q.push_back(e);
    endtask

    // Monitor: after each active edge, pop the pending expectation and compare.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk_i);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_vec++;
                check(e.name, "q_o",             q_o,                   e.q);
                check(e.name, "qe_o",            DW'(qe_o),            DW'(e.flags[4]));
                check(e.name, "phase_o",         DW'(phase_o),         DW'(e.flags[3]));
                check(e.name, "err_update_o",    DW'(err_update_o),    DW'(e.flags[2]));
                check(e.name, "err_storage_o",   DW'(err_storage_o),   DW'(e.flags[1]));
                check(e.name, "write_ignored_o", DW'(write_ignored_o), DW'(e.flags[0]));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DW-1:0] res;
        logic [DW-1:0] qu;
        res = w(6'h20, 6'h01);
        qu  = mk(6'h01, 6'h01, 6'h01, 6'h04, 6'h20, 6'h03);

        //     name             rst we re bsy wdata            flp exp q          {qe,ph,eu,es,wi}
        apply("reset",          0, 0, 0, 0, '0,              0, res,          5'b00000);
        apply("idle",           1, 0, 0, 0, '0,              0, res,          5'b00000);
        apply("mode02_a",       1, 1, 0, 0, w(6'h02, 6'h01), 0, res,          5'b01000);
        apply("mode02_b",       1, 1, 0, 0, w(6'h02, 6'h01), 0, w(6'h02,6'h01), 5'b10000);
        apply("idle2",          1, 0, 0, 0, '0,              0, w(6'h02,6'h01), 5'b00000);
        apply("mode03_a",       1, 1, 0, 0, w(6'h03, 6'h01), 0, w(6'h02,6'h01), 5'b01000);
        apply("mode03_b",       1, 1, 0, 0, w(6'h03, 6'h01), 0, w(6'h20,6'h01), 5'b10000);
        apply("kl2",            1, 1, 0, 0, w(6'h20, 6'h02), 0, w(6'h20,6'h01), 5'b01000);
        apply("kl4_mismatch",   1, 1, 0, 0, w(6'h20, 6'h04), 0, w(6'h20,6'h01), 5'b00100);
        apply("kl0_default",    1, 1, 0, 0, w(6'h20, 6'h00), 0, w(6'h20,6'h01), 5'b01000);
        apply("kl4_confirm",    1, 1, 0, 0, w(6'h20, 6'h04), 0, w(6'h20,6'h04), 5'b10000);
        apply("unmasked_a",     1, 1, 0, 0, mk(6'h3F,6'h01,6'h3F,6'h04,6'h20,6'h3F), 0, w(6'h20,6'h04), 5'b01000);
        apply("unmasked_b",     1, 1, 0, 0, mk(6'h3F,6'h01,6'h3F,6'h04,6'h20,6'h3F), 0, qu, 5'b10000);
        apply("mode04_a",       1, 1, 0, 0, w(6'h04, 6'h04), 0, qu,           5'b01000);
        apply("re_discard",     1, 0, 1, 0, '0,              0, qu,           5'b00000);
        apply("mode04_b",       1, 1, 0, 0, w(6'h04, 6'h04), 0, qu,           5'b01000);
        apply("re_we_commit",   1, 1, 1, 0, w(6'h04, 6'h04), 0, w(6'h04,6'h04), 5'b10000);
        apply("busy_a",         1, 1, 0, 1, w(6'h08, 6'h04), 0, w(6'h04,6'h04), 5'b00001);
        apply("busy_b",         1, 1, 0, 1, w(6'h08, 6'h04), 0, w(6'h04,6'h04), 5'b00001);
        apply("busy_idle",      1, 0, 0, 0, '0,              0, w(6'h04,6'h04), 5'b00000);
        apply("mode08_a",       1, 1, 0, 0, w(6'h08, 6'h04), 0, w(6'h04,6'h04), 5'b01000);
        apply("busy_staged",    1, 1, 0, 1, w(6'h10, 6'h04), 0, w(6'h04,6'h04), 5'b01001);
        apply("mode08_b",       1, 1, 0, 0, w(6'h08, 6'h04), 0, w(6'h08,6'h04), 5'b10000);
        apply("shadow_flip",    1, 0, 0, 0, '0,              1, w(6'h08,6'h04), 5'b00010);
        apply("storage_sticky", 1, 0, 0, 0, '0,              0, w(6'h08,6'h04), 5'b00010);
        apply("es_commit_a",    1, 1, 0, 0, w(6'h02, 6'h01), 0, w(6'h08,6'h04), 5'b01010);
        apply("es_commit_b",    1, 1, 0, 0, w(6'h02, 6'h01), 0, w(6'h02,6'h01), 5'b10010);
        apply("stage_pre_rst",  1, 1, 0, 0, w(6'h01, 6'h01), 0, w(6'h02,6'h01), 5'b01010);
        apply("rst_mid_seq",    0, 0, 0, 0, '0,              0, res,          5'b00000);
        apply("rst_release",    1, 0, 0, 0, '0,              0, res,          5'b00000);
        apply("post_rst_a",     1, 1, 0, 0, w(6'h01, 6'h01), 0, res,          5'b01000);
        apply("post_rst_b",     1, 1, 0, 0, w(6'h01, 6'h01), 0, w(6'h01,6'h01), 5'b10000);
        apply("final_idle",     1, 0, 0, 0, '0,              0, w(6'h01,6'h01), 5'b00000);

        for (int i = 0; i < 10; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk_i);
            #2;
        end
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_aes_ctrl_shadow_bank
